// File: rtl/eth_pkt_arb_pkg.sv
// Shared types and constants for the two-port packet arbiter (package eth_pkg).
// Words are 34 bits: [31:0] data, [32] start of packet, [33] end of packet.
package eth_pkg;
    localparam int WORD_W  = 34;
    localparam int SOP_BIT = 32;
    localparam int EOP_BIT = 33;

    typedef logic [WORD_W-1:0] eth_word_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ABORT
    } arb_state_t;
endpackage

// File: rtl/eth_pkt_arb_if.sv
// Bus bundle between the receive FIFOs, the arbiter and the shared output FIFO.
// Statistics counters exist only when ARB_STATS_EN is defined.
interface eth_pkt_arb_if;
    import eth_pkg::*;

    logic [1:0] reqEmpty;
    eth_word_t  reqData0;
    eth_word_t  reqData1;
    logic [1:0] reqRdEn;
    logic       outReady;
    logic       outWrEn;
    eth_word_t  outData;
    logic [1:0] grant;
    logic       outAbort;
`ifdef ARB_STATS_EN
    logic [15:0] pktCnt0;
    logic [15:0] pktCnt1;
    logic [15:0] abortCnt;
`endif

    modport master (
        input  reqEmpty, reqData0, reqData1, outReady,
        output reqRdEn, outWrEn, outData, grant, outAbort
`ifdef ARB_STATS_EN
        , output pktCnt0, pktCnt1, abortCnt
`endif
    );

    modport slave (
        output reqEmpty, reqData0, reqData1, outReady,
        input  reqRdEn, outWrEn, outData, grant, outAbort
`ifdef ARB_STATS_EN
        , input pktCnt0, pktCnt1, abortCnt
`endif
    );
endinterface

// File: rtl/eth_rr_arb2.sv
// Two-request round-robin chooser: one-hot grant, preferring the requester
// that did not own the bus last. The pointer itself lives in the parent.
module eth_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/eth_pkt_arb.sv
// Packet-granular round-robin merge of two show-ahead FIFOs onto one word bus,
// with stall/truncation abort. Define ARB_STATS_EN for packet/abort counters.
module eth_pkt_arb
    import eth_pkg::*;
#(
    parameter int STALL_MAX = 16   // legal range 2..255
) (
    input  logic          clk,
    input  logic          reset,
    eth_pkt_arb_if.master bus
);
    arb_state_t state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic       last_grant_reg, last_grant_next;
    logic       first_reg, first_next;
    logic [7:0] stall_cnt_reg, stall_cnt_next;
    logic       out_wr_reg, out_wr_next;
    eth_word_t  out_data_reg, out_data_next;

    eth_word_t  head [2];
    logic [1:0] sop_req;
    logic [1:0] stray;
    logic [1:0] pick;
    logic [1:0] rd_en;
    logic       g_idx;
    logic       g_empty;
    eth_word_t  g_head;
    logic       truncate;

    assign head[0] = bus.reqData0;
    assign head[1] = bus.reqData1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign sop_req[gi] = !bus.reqEmpty[gi] &&  head[gi][SOP_BIT];
            assign stray[gi]   = !bus.reqEmpty[gi] && !head[gi][SOP_BIT];
        end
    endgenerate

    eth_rr_arb2 u_rr (
        .req        (sop_req),
        .last_grant (last_grant_reg),
        .gnt        (pick)
    );

    assign g_idx    = grant_reg[1];
    assign g_empty  = bus.reqEmpty[g_idx];
    assign g_head   = head[g_idx];
    // A fresh SOP after the first word means the current packet was cut short.
    assign truncate = !g_empty && g_head[SOP_BIT] && !first_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
            first_reg      <= 1'b0;
            stall_cnt_reg  <= 8'd0;
            out_wr_reg     <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            first_reg      <= first_next;
            stall_cnt_reg  <= stall_cnt_next;
            out_wr_reg     <= out_wr_next;
            out_data_reg   <= out_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        first_next      = first_reg;
        stall_cnt_next  = stall_cnt_reg;
        out_wr_next     = 1'b0;
        out_data_next   = out_data_reg;
        unique case (state_reg)
            IDLE: begin
                if (|sop_req) begin
                    state_next     = XFER;
                    grant_next     = pick;
                    first_next     = 1'b1;
                    stall_cnt_next = 8'd0;
                end
            end
            XFER: begin
                // Back-pressure freezes everything, including the stall count.
                if (bus.outReady) begin
                    if (rd_en[g_idx]) begin
                        out_wr_next    = 1'b1;
                        out_data_next  = g_head;
                        first_next     = 1'b0;
                        stall_cnt_next = 8'd0;
                        if (g_head[EOP_BIT]) begin
                            last_grant_next = g_idx;
                            grant_next      = 2'b00;
                            state_next      = IDLE;
                        end
                    end else if (truncate) begin
                        state_next = ABORT;
                    end else begin
                        stall_cnt_next = stall_cnt_reg + 8'd1;
                        if (stall_cnt_next == 8'(STALL_MAX))
                            state_next = ABORT;
                    end
                end
            end
            ABORT: begin
                last_grant_next = g_idx;
                grant_next      = 2'b00;
                stall_cnt_next  = 8'd0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 2'b00;
        if (!reset) begin
            if (state_reg == IDLE)
                rd_en = stray;
            else if (state_reg == XFER && !g_empty && bus.outReady && !truncate)
                rd_en[g_idx] = 1'b1;
        end
    end

    assign bus.reqRdEn  = rd_en;
    assign bus.outWrEn  = out_wr_reg;
    assign bus.outData  = out_data_reg;
    assign bus.grant    = grant_reg;
    assign bus.outAbort = (state_reg == ABORT);

`ifdef ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    cnt_reg <= 16'd0;
                else if (state_reg == XFER && rd_en[gi] && head[gi][EOP_BIT] && cnt_reg != 16'hFFFF)
                    cnt_reg <= cnt_reg + 16'd1;
            end
        end
    endgenerate

    logic [15:0] abort_cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            abort_cnt_reg <= 16'd0;
        else if (state_reg == ABORT && abort_cnt_reg != 16'hFFFF)
            abort_cnt_reg <= abort_cnt_reg + 16'd1;
    end

    assign bus.pktCnt0  = g_stats[0].cnt_reg;
    assign bus.pktCnt1  = g_stats[1].cnt_reg;
    assign bus.abortCnt = abort_cnt_reg;
`endif
endmodule

// File: tb/tb_eth_pkt_arb.sv
// Scoreboard bench for eth_pkt_arb: directed packets on ports A/B, expected
// output words and aborts queued at stimulus time, compared by a monitor.
module tb_eth_pkt_arb;
    import eth_pkg::*;

    localparam int        STALL = 16;
    localparam eth_word_t SOP   = 34'h1_0000_0000;
    localparam eth_word_t EOP   = 34'h2_0000_0000;

    typedef struct packed {
        logic      ab;
        eth_word_t w;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    eth_pkt_arb_if bus ();

    eth_pkt_arb #(.STALL_MAX(STALL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t      sb [$];
    eth_word_t qa [$];
    eth_word_t qb [$];
    int        n_cmp = 0;
    int        n_err = 0;
    exp_t      mon_act;
    exp_t      mon_exp;
    logic [1:0] rd_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_word(input eth_word_t w);
        sb.push_back({1'b0, w});
    endtask

    task automatic exp_abort();
        sb.push_back({1'b1, 34'd0});
    endtask

    task automatic send_a(input eth_word_t w);
        qa.push_back(w);
        exp_word(w);
    endtask

    task automatic send_b(input eth_word_t w);
        qb.push_back(w);
        exp_word(w);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0 && bus.grant == 2'b00 && !bus.outWrEn) break;
            tick();
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Requester FIFO model: sole driver of the request-side inputs.
    task automatic refresh();
        bus.reqEmpty[0] = (qa.size() == 0);
        bus.reqEmpty[1] = (qb.size() == 0);
        bus.reqData0    = (qa.size() != 0) ? qa[0] : '0;
        bus.reqData1    = (qb.size() != 0) ? qb[0] : '0;
    endtask

    initial begin
        refresh();
        forever begin
            @(posedge clk);
            rd_s = bus.reqRdEn;
            #1;
            if (rd_s[0] && qa.size() != 0) void'(qa.pop_front());
            if (rd_s[1] && qb.size() != 0) void'(qb.pop_front());
            refresh();
            #2;
            refresh();
        end
    end

    always @(negedge clk) begin
        if (!reset && (bus.outWrEn || bus.outAbort)) begin
            mon_act.ab = bus.outAbort;
            mon_act.w  = bus.outAbort ? '0 : bus.outData;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got ab=%0b w=%h expected nothing", mon_act.ab, mon_act.w);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL out_word: got ab=%0b w=%h expected ab=%0b w=%h",
                             mon_act.ab, mon_act.w, mon_exp.ab, mon_exp.w);
                end else begin
                    $display("out ab=%0b w=%h grant=%b ok", mon_act.ab, mon_act.w, bus.grant);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.outReady = 1'b1;
        #1;
        qa.push_back(34'h0_1234_5678);   // stray head while reset is held
        #20;
        check("rst_wr",    64'(bus.outWrEn),  64'd0);
        check("rst_data",  64'(bus.outData),  64'd0);
        check("rst_grant", 64'(bus.grant),    64'd0);
        check("rst_abort", 64'(bus.outAbort), 64'd0);
        check("rst_rden",  64'(bus.reqRdEn),  64'd0);
        qa.delete();
        tick();
        reset = 1'b0;

        // single 3-word packet on A
        send_a(SOP | 34'h0000ABCD);
        send_a(34'h11111111);
        send_a(EOP | 34'h22222222);
        tick(); check("t1_grant", 64'(bus.grant), 64'd1);
        tick(); check("t1_wr0", 64'(bus.outWrEn), 64'd1);
        tick(); check("t1_wr1", 64'(bus.outWrEn), 64'd1);
        tick(); check("t1_wr2", 64'(bus.outWrEn), 64'd1);
        check("t1_grant_end", 64'(bus.grant), 64'd0);
        drain("t1_drain");

        // A and B tie after reset: A first, one idle cycle, then B
        reset = 1'b1;
        tick();
        send_a(SOP | 34'h000000A0); send_a(EOP | 34'h000000A1);
        send_b(SOP | 34'h000000B0); send_b(EOP | 34'h000000B1);
        tick();
        reset = 1'b0;
        tick(); check("t2_grant_a", 64'(bus.grant), 64'd1);
        tick();
        tick(); check("t2_grant_gap", 64'(bus.grant), 64'd0);
        tick(); check("t2_grant_b", 64'(bus.grant), 64'd2);
        check("t2_idle_wr", 64'(bus.outWrEn), 64'd0);
        tick();
        tick(); check("t2_grant_end", 64'(bus.grant), 64'd0);
        drain("t2_drain");

        // 4-word packet with back-pressure during transfer cycles 2..4
        send_a(SOP | 34'h30); send_a(34'h31); send_a(34'h32); send_a(EOP | 34'h33);
        tick(); check("t3_grant", 64'(bus.grant), 64'd1);
        tick(); check("t3_wr0", 64'(bus.outWrEn), 64'd1);
        bus.outReady = 1'b0;
        tick(); check("t3_hold0", 64'(bus.outWrEn), 64'd0);
        tick(); check("t3_hold1", 64'(bus.outWrEn), 64'd0);
        tick(); check("t3_hold2", 64'(bus.outWrEn), 64'd0);
        check("t3_no_pop", 64'(qa.size()), 64'd3);
        bus.outReady = 1'b1;
        tick(); check("t3_resume", 64'(bus.outWrEn), 64'd1);
        tick();
        tick(); check("t3_grant_end", 64'(bus.grant), 64'd0);
        drain("t3_drain");

        // stall abort after STALL cycles of empty, then queued B
        send_a(SOP | 34'h40); send_a(34'h41);
        tick(); check("t4_grant", 64'(bus.grant), 64'd1);
        exp_abort();
        send_b(SOP | 34'h50); send_b(EOP | 34'h51);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.outAbort) begin k = i; break; end
        end
        check("t4_abort_cycle", 64'(k), 64'(STALL + 2));
        check("t4_grant_abort", 64'(bus.grant), 64'd1);
        tick(); check("t4_grant_clear", 64'(bus.grant), 64'd0);
        tick(); check("t4_grant_b", 64'(bus.grant), 64'd2);
        drain("t4_drain");

        // truncation by a new SOP, with a stray word on B
        qb.push_back(34'h0_DEAD0001);
        send_a(SOP | 34'h60); send_a(34'h1);
        exp_abort();
        send_a(SOP | 34'hC0); send_a(EOP | 34'hC1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.outAbort) begin k = i; break; end
        end
        check("t5_abort_cycle", 64'(k), 64'd4);
        check("t5_stray_popped", 64'(qb.size()), 64'd0);
        drain("t5_drain");
        check("t5_a_empty", 64'(qa.size()), 64'd0);
`ifdef ARB_STATS_EN
        check("stat_pkt0",  64'(bus.pktCnt0),  64'd3);
        check("stat_pkt1",  64'(bus.pktCnt1),  64'd2);
        check("stat_abort", 64'(bus.abortCnt), 64'd2);
`endif

        // reset mid-packet, then A must win the first tie
        send_a(SOP | 34'h61); send_a(34'h62); send_a(34'h63); send_a(EOP | 34'h64);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("t6_wr",    64'(bus.outWrEn),  64'd0);
        check("t6_data",  64'(bus.outData),  64'd0);
        check("t6_grant", 64'(bus.grant),    64'd0);
        check("t6_abort", 64'(bus.outAbort), 64'd0);
        check("t6_rden",  64'(bus.reqRdEn),  64'd0);
        sb.delete();
        qa.delete();
        tick();
        send_a(SOP | 34'h71); send_a(EOP | 34'h72);
        send_b(SOP | 34'h81); send_b(EOP | 34'h82);
`ifdef ARB_STATS_EN
        check("stat_rst_pkt0",  64'(bus.pktCnt0),  64'd0);
        check("stat_rst_abort", 64'(bus.abortCnt), 64'd0);
`endif
        tick();
        reset = 1'b0;
        tick(); check("t6_grant_a", 64'(bus.grant), 64'd1);
        drain("t6_drain");
`ifdef ARB_STATS_EN
        check("stat_end_pkt0",  64'(bus.pktCnt0),  64'd1);
        check("stat_end_abort", 64'(bus.abortCnt), 64'd0);
`endif
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
